// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the HI/LO multiply/divide sequencer.
//   - op encodings presented by the control unit (MULT, DIV, MTHI, MTLO)
//   - sequencer FSM state encoding
//   - default iteration counts for the multiplier and divider units
package muldiv_pkg;

  localparam int MULT_CYCLES = 32;
  localparam int DIV_CYCLES  = 32;
  localparam int CNT_W       = 6;

  typedef enum logic [1:0] {
    OP_MULT = 2'b00,
    OP_DIV  = 2'b01,
    OP_MTHI = 2'b10,
    OP_MTLO = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_CLEAR   = 2'b01,
    ST_RUN     = 2'b10,
    ST_CAPTURE = 2'b11
  } state_e;

endpackage

// File: rtl/muldiv_sequencer_iter_counter.sv
// iter_counter: iteration counter for the multiply/divide RUN phase.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   load       : synchronous load-to-zero (takes priority over en)
//   en         : count enable
//   last       : terminal value (N-1 for an N-iteration operation)
//   tc         : high while the count equals last
module iter_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] last,
  output logic             tc
);

  logic [CNT_W-1:0] count_r;

  // Count register: only moves when enabled, so it never free-runs outside RUN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= '0;
    end else if (en) begin
      count_r <= count_r + CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign tc = (count_r == last);

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: sequences the iterative multiplier and divider and owns HI/LO.
// Ports:
//   clk, reset              : clock, asynchronous active-high reset
//   op_valid, op, op_ready  : request handshake (MULT/DIV/MTHI/MTLO)
//   rs_val, rt_val          : operands (rs_val is also the MTHI/MTLO source)
//   flush                   : cancel any in-flight operation
//   mf_rd, stall            : MFHI/MFLO issue and the resulting stall
//   unit_a, unit_b          : latched operands shared by both units
//   mult_clr/run, div_clr/run : per-unit clear pulse and iterate enable
//   mult_hi/lo, div_hi/lo   : unit results (divider: hi=remainder, lo=quotient)
//   hi, lo                  : architectural HI/LO
//   busy, done, div_zero    : status; done and div_zero are one-cycle pulses
module muldiv_sequencer #(
  parameter int MULT_CYCLES = muldiv_pkg::MULT_CYCLES,
  parameter int DIV_CYCLES  = muldiv_pkg::DIV_CYCLES,
  parameter int CNT_W       = muldiv_pkg::CNT_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [1:0]  op,
  output logic        op_ready,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        flush,
  input  logic        mf_rd,
  output logic        stall,
  output logic [31:0] unit_a,
  output logic [31:0] unit_b,
  output logic        mult_clr,
  output logic        mult_run,
  output logic        div_clr,
  output logic        div_run,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);
  import muldiv_pkg::*;

  state_e           state_r;
  logic             sel_div_r;
  op_e              op_s;
  logic             accept_s;
  logic             cnt_load_s;
  logic             cnt_en_s;
  logic             tc_s;
  logic [CNT_W-1:0] last_s;

  assign op_s       = op_e'(op);
  assign op_ready   = (state_r == ST_IDLE) & ~flush;
  assign accept_s   = op_valid & op_ready;
  assign busy       = (state_r != ST_IDLE);
  assign stall      = mf_rd & busy;
  // Counter restarts from zero on the CLEAR->RUN edge and only counts in RUN.
  assign cnt_load_s = (state_r == ST_CLEAR);
  assign cnt_en_s   = (state_r == ST_RUN);
  assign last_s     = sel_div_r ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);

  iter_counter #(.CNT_W(CNT_W)) u_iter_counter (
    .clk   (clk),
    .reset (reset),
    .load  (cnt_load_s),
    .en    (cnt_en_s),
    .last  (last_s),
    .tc    (tc_s)
  );

  // Sequencer FSM with operand latches, HI/LO and all registered unit controls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      sel_div_r <= 1'b0;
      unit_a    <= 32'd0;
      unit_b    <= 32'd0;
      hi        <= 32'd0;
      lo        <= 32'd0;
      mult_clr  <= 1'b0;
      mult_run  <= 1'b0;
      div_clr   <= 1'b0;
      div_run   <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      mult_clr <= 1'b0;
      div_clr  <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            case (op_s)
              OP_MTHI: hi <= rs_val;
              OP_MTLO: lo <= rs_val;
              OP_MULT, OP_DIV: begin
                if ((op_s == OP_DIV) && (rt_val == 32'd0)) begin
                  // Rejected before touching either unit.
                  div_zero <= 1'b1;
                end else begin
                  unit_a    <= rs_val;
                  unit_b    <= rt_val;
                  sel_div_r <= (op_s == OP_DIV);
                  mult_clr  <= (op_s == OP_MULT);
                  div_clr   <= (op_s == OP_DIV);
                  state_r   <= ST_CLEAR;
                end
              end
              default: state_r <= ST_IDLE;
            endcase
          end
        end
        ST_CLEAR, ST_RUN, ST_CAPTURE: begin
          if (flush) begin
            // Leave the cancelled unit cleared; flush wins over capture.
            state_r  <= ST_IDLE;
            mult_run <= 1'b0;
            div_run  <= 1'b0;
            mult_clr <= ~sel_div_r;
            div_clr  <= sel_div_r;
          end else if (state_r == ST_CLEAR) begin
            state_r  <= ST_RUN;
            mult_run <= ~sel_div_r;
            div_run  <= sel_div_r;
          end else if (state_r == ST_RUN) begin
            if (tc_s) begin
              state_r  <= ST_CAPTURE;
              mult_run <= 1'b0;
              div_run  <= 1'b0;
            end else begin
              state_r <= ST_RUN;
            end
          end else begin
            hi      <= sel_div_r ? div_hi : mult_hi;
            lo      <= sel_div_r ? div_lo : mult_lo;
            done    <= 1'b1;
            state_r <= ST_IDLE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer. Behavioural multiplier/divider units
// only present the correct result after exactly 32 run cycles since their clear.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset, op_valid, flush, mf_rd, op_ready, stall;
  logic [1:0]  op;
  logic [31:0] rs_val, rt_val, unit_a, unit_b, hi, lo;
  logic [31:0] mult_hi, mult_lo, div_hi, div_lo;
  logic        mult_clr, mult_run, div_clr, div_run, busy, done, div_zero;

  always #5 clk = ~clk;

  muldiv_sequencer dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .op_ready(op_ready),
    .rs_val(rs_val), .rt_val(rt_val), .flush(flush), .mf_rd(mf_rd), .stall(stall),
    .unit_a(unit_a), .unit_b(unit_b), .mult_clr(mult_clr), .mult_run(mult_run),
    .div_clr(div_clr), .div_run(div_run), .mult_hi(mult_hi), .mult_lo(mult_lo),
    .div_hi(div_hi), .div_lo(div_lo), .hi(hi), .lo(lo), .busy(busy), .done(done),
    .div_zero(div_zero)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Reference arithmetic: signed product, signed truncating divide.
  function automatic logic [63:0] ref_mult(input logic [31:0] a, input logic [31:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p;
  endfunction

  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    int ia, ib;
    ia = a;
    ib = b;
    if (ib == 0 || (a == 32'h8000_0000 && ib == -1)) return 64'd0;
    return {ia % ib, ia / ib};
  endfunction

  // Behavioural iterative units.
  int mcnt, dcnt;
  always @(posedge clk or posedge reset) begin
    if (reset) begin mcnt <= 0; dcnt <= 0; end
    else begin
      if (mult_clr) mcnt <= 0; else if (mult_run) mcnt <= mcnt + 1;
      if (div_clr)  dcnt <= 0; else if (div_run)  dcnt <= dcnt + 1;
    end
  end
  assign {mult_hi, mult_lo} = (mcnt == 32) ? ref_mult(unit_a, unit_b) : {32'hBAD0_0000, 32'(mcnt)};
  assign {div_hi, div_lo}   = (dcnt == 32) ? ref_div(unit_a, unit_b)  : {32'hBAD1_0000, 32'(dcnt)};

  // Expected-behaviour model state.
  typedef struct { logic [31:0] hi; logic [31:0] lo; int done_cyc; } exp_t;
  exp_t sb[$];
  int   dzq[$];
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
  logic cur_div = 1'b0;
  int busy_from = -10, busy_to = -10, run_from = -10, run_to = -10, clr1 = -10, clr2 = -10;
  bit force_mf = 1'b0;

  initial begin
    mf_rd = 1'b0;
    forever begin
      @(posedge clk); #1;
      mf_rd = force_mf ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  // Monitor: per-cycle expectations and scoreboard pops.
  logic mon_eb, mon_er, mon_ec, mon_ed, mon_edz;
  exp_t mon_e;
  always @(negedge clk) begin
    if (!reset) begin
      mon_eb = (cyc >= busy_from) && (cyc <= busy_to);
      mon_er = (cyc >= run_from) && (cyc <= run_to);
      mon_ec = (cyc == clr1) || (cyc == clr2);
      check("busy", busy, mon_eb);
      check("stall", stall, mf_rd & mon_eb);
      check("unit_ctl", {mult_clr, mult_run, div_clr, div_run},
            {mon_ec & ~cur_div, mon_er & ~cur_div, mon_ec & cur_div, mon_er & cur_div});
      mon_edz = (dzq.size() > 0) && (dzq[0] == cyc);
      check("div_zero", div_zero, mon_edz);
      if (mon_edz) void'(dzq.pop_front());
      mon_ed = (sb.size() > 0) && (sb[0].done_cyc == cyc);
      check("done", done, mon_ed);
      if (mon_ed) begin
        mon_e = sb.pop_front();
        check("result", {hi, lo}, {mon_e.hi, mon_e.lo});
        m_hi = mon_e.hi;
        m_lo = mon_e.lo;
      end else begin
        check("hilo_hold", {hi, lo}, {m_hi, m_lo});
      end
    end
  end

  // mode 0: return after accept; 1: wait until done; 2: wait with junk requests.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input int mode);
    int c0, w;
    exp_t e;
    logic [63:0] r;
    w = 0;
    while (!op_ready && w < 100) begin @(posedge clk); #1; w++; end
    if (!op_ready) begin check("ready_timeout", 1'b0, 1'b1); return; end
    op_valid = 1'b1; op = o; rs_val = a; rt_val = b; c0 = cyc;
    @(posedge clk); #1;
    op_valid = 1'b0;
    if (o == OP_MTHI) m_hi = a;
    else if (o == OP_MTLO) m_lo = a;
    else if (o == OP_DIV && b == 32'd0) dzq.push_back(c0 + 1);
    else begin
      r = (o == OP_DIV) ? ref_div(a, b) : ref_mult(a, b);
      e.hi = r[63:32]; e.lo = r[31:0]; e.done_cyc = c0 + 35;
      sb.push_back(e);
      cur_div = (o == OP_DIV);
      busy_from = c0 + 1; busy_to = c0 + 34;
      clr1 = c0 + 1; clr2 = -10;
      run_from = c0 + 2; run_to = c0 + 33;
      if (mode != 0) begin
        while (cyc <= busy_to) begin
          rs_val = $urandom; rt_val = $urandom;
          if (mode == 2) begin op_valid = 1'b1; op = 2'($urandom); end
          @(posedge clk); #1;
        end
        op_valid = 1'b0;
      end
    end
  endtask

  task automatic do_flush(input int last_run);
    flush = 1'b1;
    sb.delete();
    busy_to = cyc; run_to = last_run; clr2 = cyc + 1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  logic [31:0] ra, rb;
  logic [1:0]  ro;
  initial begin
    reset = 1'b1; op_valid = 1'b0; op = 2'd0; rs_val = 32'd0; rt_val = 32'd0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_regs", {hi, lo, unit_a, unit_b}, 128'd0);
    check("reset_ctl", {busy, mult_clr, mult_run, div_clr, div_run, done, div_zero}, 7'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    issue(OP_MULT, 32'd7, 32'hFFFF_FFFD, 1);
    check("mult_7x-3", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFEB});
    issue(OP_DIV, 32'd100, 32'd7, 1);
    check("div_100/7", {hi, lo}, {32'd2, 32'd14});
    issue(OP_DIV, 32'd50, 32'd0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("divzero_keep", {hi, lo}, {32'd2, 32'd14});

    issue(OP_MTHI, 32'hDEAD_BEEF, 32'd0, 0);
    check("mthi_now", hi, 32'hDEAD_BEEF);
    force_mf = 1'b1;
    issue(OP_MULT, $urandom, $urandom, 1);
    force_mf = 1'b0;

    // Flush in RUN with the count at 10.
    issue(OP_MULT, 32'd123, 32'd456, 0);
    repeat (11) begin @(posedge clk); #1; end
    do_flush(cyc);
    repeat (40) begin @(posedge clk); #1; end
    // Flush in CAPTURE wins over the capture.
    issue(OP_DIV, 32'd999, 32'd10, 0);
    repeat (33) begin @(posedge clk); #1; end
    do_flush(cyc - 1);
    repeat (5) begin @(posedge clk); #1; end
    // Flush while IDLE blocks acceptance.
    check("ready_idle", op_ready, 1'b1);
    flush = 1'b1; op_valid = 1'b1; op = OP_MTLO; rs_val = 32'h1234_5678;
    #1;
    check("ready_flush", op_ready, 1'b0);
    @(posedge clk); #1;
    flush = 1'b0; op_valid = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom); ra = $urandom; rb = $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'd0;
      if (ra == 32'h8000_0000) ra = 32'd1;
      issue(ro, ra, rb, 2);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    // Reset mid-RUN, then a normal MULT.
    issue(OP_MULT, 32'd77, 32'd88, 0);
    repeat (10) begin @(posedge clk); #1; end
    reset = 1'b1;
    #1;
    check("midreset_regs", {hi, lo, unit_a, unit_b}, 128'd0);
    check("midreset_ctl", {busy, mult_clr, mult_run, div_clr, div_run, done, div_zero}, 7'd0);
    sb.delete(); dzq.delete(); m_hi = 32'd0; m_lo = 32'd0;
    busy_to = -10; run_to = -10; clr1 = -10; clr2 = -10;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    issue(OP_MULT, 32'hFFFF_FFF0, 32'd3, 1);
    check("post_reset_mult", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFD0});

    repeat (3) begin @(posedge clk); #1; end
    check("sb_empty", sb.size(), 0);
    check("dz_empty", dzq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
